// File: rtl/rom_loader_qspi_writer_if.sv
// rtl/rom_loader_qspi_writer_if.sv - ROM loader load/sck/data/ack handshake bundle
interface rom_loader_qspi_writer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  load;
    logic                  sck;
    logic [DATA_WIDTH-1:0] data;
    logic                  ack;

    modport master (output load, output sck, output data, input ack);
    modport slave  (input load, input sck, input data, output ack);
endinterface

// File: rtl/rom_loader_qspi_writer.sv
// rtl/rom_loader_qspi_writer.sv - ROM loader responder writing words into SQI serial SRAM
module rom_loader_qspi_writer #(
    parameter int          DATA_WIDTH    = 16,
    parameter int          ADDRESS_WIDTH = 16,
    parameter logic [7:0]  WRITE_CMD     = 8'h02
) (
    input  logic                     clk,
    input  logic                     reset,
    rom_loader_qspi_writer_if.slave  rom_loader,
    output logic                     rom_loader_active,
    output logic                     rom_cs_n,
    output logic                     rom_sck,
    output logic                     rom_sio_oe,
    output logic [3:0]               rom_sio_o,
    output logic [ADDRESS_WIDTH-1:0] word_count
);
    // Zero padding that turns a word index into a 24-bit byte address.
    localparam int PAD = 23 - ADDRESS_WIDTH;

    typedef enum logic [1:0] {IDLE, SHIFT, DESEL, ACK} state_t;

    state_t                   state;
    logic                     sck_q;
    logic                     load_q;
    logic [ADDRESS_WIDTH-1:0] index;
    // Nibbles still to be driven after the one currently on rom_sio_o.
    logic [43:0]              shreg;
    logic [4:0]               t;

    logic                     sck_rise;
    logic                     load_rise;
    logic [ADDRESS_WIDTH-1:0] index_eff;
    logic [23:0]              byte_addr;

    // Strobe/session edge detection; a session start in the same cycle as a strobe writes address 0.
    always_comb begin
        sck_rise  = !sck_q && rom_loader.sck;
        load_rise = !load_q && rom_loader.load;
        index_eff = load_rise ? '0 : index;
        byte_addr = {{PAD{1'b0}}, index_eff, 1'b0};
    end

    // The SoC uses this to hand the ROM pins to this block.
    assign rom_loader_active = rom_loader.load | (state != IDLE);

    // Write FSM: command, address, data nibbles with SRAM sampling on rom_sck rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sck_q          <= 1'b0;
            load_q         <= 1'b0;
            index          <= '0;
            word_count     <= '0;
            shreg          <= '0;
            t              <= '0;
            rom_cs_n       <= 1'b1;
            rom_sck        <= 1'b0;
            rom_sio_oe     <= 1'b0;
            rom_sio_o      <= 4'h0;
            rom_loader.ack <= 1'b0;
        end else begin
            sck_q  <= rom_loader.sck;
            load_q <= rom_loader.load;
            case (state)
                IDLE: begin
                    if (sck_rise && rom_loader.load) begin
                        state      <= SHIFT;
                        rom_cs_n   <= 1'b0;
                        rom_sck    <= 1'b0;
                        rom_sio_oe <= 1'b1;
                        rom_sio_o  <= WRITE_CMD[7:4];
                        shreg      <= {WRITE_CMD[3:0], byte_addr, rom_loader.data};
                        t          <= '0;
                    end
                end
                SHIFT: begin
                    t <= t + 5'd1;
                    if (t == 5'd23) begin
                        state      <= DESEL;
                        rom_cs_n   <= 1'b1;
                        rom_sck    <= 1'b0;
                        rom_sio_oe <= 1'b0;
                        rom_sio_o  <= 4'h0;
                    end else if (!t[0]) begin
                        rom_sck <= 1'b1;
                    end else begin
                        // Falling edge of rom_sck: present the next nibble for the following rise.
                        rom_sck   <= 1'b0;
                        rom_sio_o <= shreg[43:40];
                        shreg     <= {shreg[39:0], 4'h0};
                    end
                end
                DESEL: begin
                    index <= index + 1'b1;
                    if (word_count != '1) begin
                        word_count <= word_count + 1'b1;
                    end
                    if (rom_loader.load) begin
                        state          <= ACK;
                        rom_loader.ack <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK: begin
                    if (!rom_loader.sck || !rom_loader.load) begin
                        rom_loader.ack <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load_rise) begin
                index      <= '0;
                word_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rom_loader_qspi_writer.sv
// tb/tb_rom_loader_qspi_writer.sv - scoreboard bench for rom_loader_qspi_writer
module tb_rom_loader_qspi_writer;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rom_loader_active;
    logic          rom_cs_n;
    logic          rom_sck;
    logic          rom_sio_oe;
    logic [3:0]    rom_sio_o;
    logic [AW-1:0] word_count;

    rom_loader_qspi_writer_if #(.DATA_WIDTH(16)) lif ();

    rom_loader_qspi_writer #(
        .DATA_WIDTH(16),
        .ADDRESS_WIDTH(AW),
        .WRITE_CMD(8'h02)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rom_loader(lif),
        .rom_loader_active(rom_loader_active),
        .rom_cs_n(rom_cs_n),
        .rom_sck(rom_sck),
        .rom_sio_oe(rom_sio_oe),
        .rom_sio_o(rom_sio_o),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cnt;
        logic [47:0] val;
    } exp_t;

    exp_t    sb_q[$];
    int      checks = 0;
    int      errors = 0;
    logic [AW-1:0] exp_idx = '0;
    logic [AW-1:0] exp_wc = '0;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: gather nibbles on each rom_sck rise inside a frame, compare at deselect.
    logic        in_frame = 1'b0;
    logic        prev_sck = 1'b0;
    logic [47:0] frame = '0;
    int          nib_cnt = 0;
    always @(negedge clk) begin
        if (rom_cs_n === 1'b0) begin
            in_frame = 1'b1;
            if (rom_sck === 1'b1 && prev_sck === 1'b0) begin
                frame = {frame[43:0], rom_sio_o};
                nib_cnt++;
                check("sio_oe_in_frame", 48'(rom_sio_oe), 48'd1);
            end
        end else if (in_frame) begin
            exp_t e;
            in_frame = 1'b0;
            if (sb_q.size() == 0) begin
                check("unexpected_frame", frame, 48'hFFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("frame_nibbles", 48'(nib_cnt), 48'(e.cnt));
                check("frame_value", frame, e.val);
            end
            frame   = '0;
            nib_cnt = 0;
        end
        prev_sck = rom_sck;
    end

    task automatic start_session();
        @(posedge clk); #1;
        lif.load = 1'b1;
        exp_idx  = '0;
        exp_wc   = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic end_session();
        @(posedge clk); #1;
        lif.load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One word transfer; abort_t >= 1 drops load in that SHIFT cycle, stray adds a strobe during SHIFT.
    task automatic write_word(input logic [15:0] d, input int abort_t, input bit stray);
        exp_t e;
        int   n;
        int   m;
        bit   seen;
        e.cnt = 12;
        e.val = {8'h02, {19'b0, exp_idx, 1'b0}, d};
        sb_q.push_back(e);
        @(posedge clk); #1;
        lif.data = d;
        lif.sck  = 1'b1;
        n = cyc;
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (rom_cs_n === 1'b0) seen = 1;
        end
        check("cs_low_cycle", 48'(seen ? cyc - n : -1), 48'd1);
        if (abort_t > 0) begin
            repeat (abort_t) @(posedge clk);
            #1 lif.load = 1'b0;
        end
        if (stray) begin
            @(posedge clk); #1 lif.sck = 1'b0;
            @(posedge clk); #1 lif.sck = 1'b1;
        end
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rom_cs_n === 1'b1) seen = 1;
        end
        check("cs_high_cycle", 48'(seen ? cyc - n : -1), 48'd25);
        exp_idx = exp_idx + 1'b1;
        if (exp_wc != '1) exp_wc = exp_wc + 1'b1;
        if (abort_t > 0) begin
            check("active_in_desel", 48'(rom_loader_active), 48'd1);
            @(negedge clk);
            check("active_after_abort", 48'(rom_loader_active), 48'd0);
            check("word_count_abort", 48'(word_count), 48'(exp_wc));
            repeat (3) begin
                @(negedge clk);
                check("no_ack_on_abort", 48'(lif.ack), 48'd0);
            end
            lif.sck = 1'b0;
        end else begin
            @(negedge clk);
            check("ack_cycle", 48'(cyc - n), 48'd26);
            check("ack_high", 48'(lif.ack), 48'd1);
            check("word_count", 48'(word_count), 48'(exp_wc));
            @(posedge clk); #1 lif.sck = 1'b0;
            m = cyc;
            @(negedge clk);
            check("ack_held", 48'(lif.ack), 48'd1);
            @(negedge clk);
            check("ack_drop_cycle", 48'(cyc - m), 48'd1);
            check("ack_low", 48'(lif.ack), 48'd0);
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        bit   seen;
        lif.load = 1'b0;
        lif.sck  = 1'b0;
        lif.data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 48'(rom_cs_n), 48'd1);
        check("rst_sck", 48'(rom_sck), 48'd0);
        check("rst_oe", 48'(rom_sio_oe), 48'd0);
        check("rst_sio", 48'(rom_sio_o), 48'd0);
        check("rst_ack", 48'(lif.ack), 48'd0);
        check("rst_word_count", 48'(word_count), 48'd0);
        check("rst_active", 48'(rom_loader_active), 48'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single word
        start_session();
        check("active_load", 48'(rom_loader_active), 48'd1);
        write_word(16'hABCD, -1, 0);
        end_session();

        // Consecutive words in a fresh session
        start_session();
        write_word(16'h1234, -1, 0);
        write_word(16'h5678, -1, 0);
        end_session();

        // Index wrap and word_count saturation
        start_session();
        for (int i = 0; i < 17; i++) write_word(16'hC000 + 16'(i), -1, 0);
        check("word_count_sat", 48'(word_count), 48'd15);
        end_session();

        // Load dropped mid-write
        start_session();
        write_word(16'h0F0F, 10, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-write at SHIFT t=7
        start_session();
        e.cnt = 4;
        e.val = 48'h0200;
        sb_q.push_back(e);
        @(posedge clk); #1;
        lif.data = 16'hBEEF;
        lif.sck  = 1'b1;
        n = cyc;
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (rom_cs_n === 1'b0) seen = 1;
        end
        check("rst_test_cs_low", 48'(seen ? cyc - n : -1), 48'd1);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        lif.sck = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", 48'(rom_cs_n), 48'd1);
        check("midrst_sck", 48'(rom_sck), 48'd0);
        check("midrst_oe", 48'(rom_sio_oe), 48'd0);
        check("midrst_ack", 48'(lif.ack), 48'd0);
        check("midrst_word_count", 48'(word_count), 48'd0);
        exp_idx = '0;
        exp_wc  = '0;
        repeat (2) @(posedge clk);
        #1;
        write_word(16'h7777, -1, 0);
        end_session();

        // Stray strobe during SHIFT, then session restart
        start_session();
        write_word(16'h2468, -1, 1);
        write_word(16'h1357, -1, 0);
        end_session();
        start_session();
        write_word(16'h9ABC, -1, 0);
        end_session();

        repeat (30) @(posedge clk);
        check("scoreboard_empty", 48'(sb_q.size()), 48'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
